// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Purpose  : Control/status bundle between the instruction sequencer and the
//            surrounding datapath (decoded flags in, strobes/status out).
// Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  // Decoded instruction flags and handshakes toward the sequencer
  logic             Start;
  logic             BranchEn;
  logic             RegWrEn;
  logic             MemWrEn;
  logic             LoadInst;
  logic             Ack;
  logic             Taken;
  logic             MemReady;

  // Datapath strobes and status from the sequencer
  logic             IRWrEn;
  logic             PCEn;
  logic             PCLoad;
  logic             RegFileWe;
  logic             WbSel;
  logic             MemReq;
  logic             MemWe;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic [CNT_W-1:0] InstCount;

  // Datapath side: supplies flags, consumes strobes
  modport master (
    output Start, BranchEn, RegWrEn, MemWrEn, LoadInst, Ack, Taken, MemReady,
    input  IRWrEn, PCEn, PCLoad, RegFileWe, WbSel, MemReq, MemWe,
    input  Busy, Done, Err, InstCount
  );

  // Sequencer side
  modport slave (
    input  Start, BranchEn, RegWrEn, MemWrEn, LoadInst, Ack, Taken, MemReady,
    output IRWrEn, PCEn, PCLoad, RegFileWe, WbSel, MemReq, MemWe,
    output Busy, Done, Err, InstCount
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Multi-cycle instruction sequencer. Walks each instruction through
//            FETCH / DECODE / EXEC / MEM / WB, raises the datapath strobes,
//            counts retired instructions and traps memory timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,  // 1..255 MEM cycles before ERR
  parameter int unsigned CNT_W       = 16   // retired-instruction counter width
) (
  input  wire logic         Clk,
  input  wire logic         Reset,  // asynchronous, active-low
  instr_sequencer_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  // The wait counter only has to reach MEM_TIMEOUT-1 (at most 254)
  localparam int unsigned      WAIT_W    = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Combinational strobe values before they reach the interface
  logic ir_wr_en;
  logic pc_en;
  logic pc_load;
  logic rf_we;
  logic wb_sel;
  logic mem_req;
  logic mem_we;

  // A store wins whenever MemWrEn is set, even if LoadInst is also set
  logic is_store;
  assign is_store = bus.MemWrEn;

  // Next-state selection from current state and decoded flags
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Ack halts regardless of any other flag of this instruction
        state_d = bus.Ack ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.BranchEn)                       state_d = ST_FETCH;
        else if (bus.MemWrEn || bus.LoadInst)   state_d = ST_MEM;
        else                                    state_d = ST_WB;
      end
      ST_MEM: begin
        // A completion in the last allowed cycle beats the timeout
        if (bus.MemReady)              state_d = is_store ? ST_FETCH : ST_WB;
        else if (wait_q == WAIT_LAST)  state_d = ST_ERR;
        else                           state_d = ST_MEM;
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (bus.Start) state_d = ST_FETCH;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // MEM wait counter: counts consecutive MEM cycles, zero on every entry
  always_comb begin
    wait_d = '0;
    if ((state_q == ST_MEM) && (state_d == ST_MEM)) begin
      wait_d = wait_q + WAIT_ONE;
    end
  end

  // Datapath strobes decoded from the current state (plus live flags)
  always_comb begin
    ir_wr_en = 1'b0;
    pc_en    = 1'b0;
    pc_load  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_wr_en = 1'b1;
      end
      ST_EXEC: begin
        if (bus.BranchEn) begin
          pc_en   = 1'b1;
          pc_load = bus.Taken;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = bus.MemWrEn;
        // A store retires in the cycle its memory access completes
        if (bus.MemReady && is_store) pc_en = 1'b1;
      end
      ST_WB: begin
        rf_we  = bus.RegWrEn;
        wb_sel = bus.LoadInst;
        pc_en  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Retired-instruction counter: cleared on restart from HALT, saturating
  always_comb begin
    count_d = count_q;
    if ((state_q == ST_HALT) && bus.Start) begin
      count_d = '0;
    end else if (pc_en && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // State, wait counter and instruction counter registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  assign bus.IRWrEn    = ir_wr_en;
  assign bus.PCEn      = pc_en;
  assign bus.PCLoad    = pc_load;
  assign bus.RegFileWe = rf_we;
  assign bus.WbSel     = wb_sel;
  assign bus.MemReq    = mem_req;
  assign bus.MemWe     = mem_we;
  assign bus.Busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                         (state_q == ST_EXEC)  || (state_q == ST_MEM)    ||
                         (state_q == ST_WB);
  assign bus.Done      = (state_q == ST_HALT);
  assign bus.Err       = (state_q == ST_ERR);
  assign bus.InstCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench: directed vector table, random instruction
//            stream against an instruction-level model, and hand-written
//            sequences for reset, timeout and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  // Input vector bits {Start,BranchEn,RegWrEn,MemWrEn,LoadInst,Ack,Taken,MemReady}
  localparam logic [7:0] I_ST  = 8'h80;
  localparam logic [7:0] I_BR  = 8'h40;
  localparam logic [7:0] I_RW  = 8'h20;
  localparam logic [7:0] I_MW  = 8'h10;
  localparam logic [7:0] I_LD  = 8'h08;
  localparam logic [7:0] I_ACK = 8'h04;
  localparam logic [7:0] I_TK  = 8'h02;
  localparam logic [7:0] I_RDY = 8'h01;

  // Output vector bits
  localparam logic [9:0] O_IR   = 10'h200;
  localparam logic [9:0] O_PCE  = 10'h100;
  localparam logic [9:0] O_PCL  = 10'h080;
  localparam logic [9:0] O_RFW  = 10'h040;
  localparam logic [9:0] O_WBS  = 10'h020;
  localparam logic [9:0] O_MRQ  = 10'h010;
  localparam logic [9:0] O_MWE  = 10'h008;
  localparam logic [9:0] O_BSY  = 10'h004;
  localparam logic [9:0] O_DONE = 10'h002;
  localparam logic [9:0] O_ERR  = 10'h001;

  typedef struct {
    logic [7:0]  in;
    logic [9:0]  exp;
    logic [15:0] cnt;
    string       name;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Reset4 = 1'b0;
  always #5 Clk = ~Clk;

  instr_sequencer_if #(.CNT_W(16)) bus ();
  instr_sequencer_if #(.CNT_W(4))  bus4 ();

  instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
    .Clk   (Clk),
    .Reset (Reset4),
    .bus   (bus4)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;   // model of InstCount for the main instance
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.IRWrEn, bus.PCEn, bus.PCLoad, bus.RegFileWe, bus.WbSel,
            bus.MemReq, bus.MemWe, bus.Busy, bus.Done, bus.Err};
  endfunction

  function automatic logic [9:0] outs4();
    return {bus4.IRWrEn, bus4.PCEn, bus4.PCLoad, bus4.RegFileWe, bus4.WbSel,
            bus4.MemReq, bus4.MemWe, bus4.Busy, bus4.Done, bus4.Err};
  endfunction

  task automatic drive(input logic [7:0] in);
    {bus.Start, bus.BranchEn, bus.RegWrEn, bus.MemWrEn,
     bus.LoadInst, bus.Ack, bus.Taken, bus.MemReady} = in;
  endtask

  task automatic add(input logic [7:0] in, input logic [9:0] exp,
                     input logic [15:0] cnt, input string nm);
    vec_t v;
    v.in = in; v.exp = exp; v.cnt = cnt; v.name = nm;
    tbl.push_back(v);
  endtask

  // One clock cycle: apply inputs just after the edge, check mid-cycle,
  // then advance to just after the next rising edge.
  task automatic cyc(input logic [7:0] in, input logic [9:0] exp,
                     input int cnt, input string nm);
    drive(in);
    #2;
    chk({nm, " outs"}, 32'(outs()), 32'(exp));
    chk({nm, " count"}, 32'(bus.InstCount), 32'(cnt));
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] nz_st();
    return ($urandom_range(0, 1) == 1) ? I_ST : 8'h00;
  endfunction

  function automatic logic [7:0] nz_rdy();
    return ($urandom_range(0, 1) == 1) ? I_RDY : 8'h00;
  endfunction

  task automatic retire();
    if (m_cnt != 65535) m_cnt++;
  endtask

  // Instruction-level model: given one instruction's flags and its memory
  // latency (lat wait cycles before MemReady), produce the expected trace.
  // Entered just after the edge that starts FETCH.
  task automatic run_instr(input bit ack, input bit br, input bit rw,
                           input bit mw, input bit ld, input bit tk,
                           input int lat);
    logic [7:0] f;
    logic [9:0] e;
    f = {1'b0, br, rw, mw, ld, ack, tk, 1'b0};
    cyc(f | nz_st() | nz_rdy(), O_IR | O_BSY, m_cnt, "fetch");
    cyc(f | nz_st() | nz_rdy(), O_BSY, m_cnt, "decode");
    if (ack) begin
      cyc(f | nz_rdy(), O_DONE, m_cnt, "halt");
      cyc(f | I_ST, O_DONE, m_cnt, "halt restart");
      m_cnt = 0;
      return;
    end
    if (br) begin
      e = O_PCE | O_BSY | (tk ? O_PCL : 10'h0);
      cyc(f | nz_st() | nz_rdy(), e, m_cnt, "exec branch");
      retire();
      return;
    end
    cyc(f | nz_st() | nz_rdy(), O_BSY, m_cnt, "exec");
    if (mw || ld) begin
      for (int k = 0; k <= lat; k++) begin
        e = O_MRQ | O_BSY | (mw ? O_MWE : 10'h0);
        if (k == lat && mw) e = e | O_PCE;
        cyc(f | nz_st() | ((k == lat) ? I_RDY : 8'h00), e, m_cnt, "mem");
      end
      if (mw) begin
        retire();
        return;
      end
    end
    e = O_PCE | O_BSY | (rw ? O_RFW : 10'h0) | (ld ? O_WBS : 10'h0);
    cyc(f | nz_st() | nz_rdy(), e, m_cnt, "wb");
    retire();
  endtask

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- directed vector table ----------------
    add(8'h00,                 10'h000,              0, "idle");
    add(I_ST,                  10'h000,              0, "idle start");
    add(I_RW,                  O_IR | O_BSY,         0, "alu fetch");
    add(I_RW | I_ST,           O_BSY,                0, "alu decode");
    add(I_RW,                  O_BSY,                0, "alu exec");
    add(I_RW,                  O_PCE | O_RFW | O_BSY, 0, "alu wb");
    add(I_BR | I_TK | I_RW,    O_IR | O_BSY,         1, "brt fetch");
    add(I_BR | I_TK | I_RW,    O_BSY,                1, "brt decode");
    add(I_BR | I_TK | I_RW,    O_PCE | O_PCL | O_BSY, 1, "brt exec");
    add(I_BR | I_RW,           O_IR | O_BSY,         2, "brn fetch");
    add(I_BR | I_RW,           O_BSY,                2, "brn decode");
    add(I_BR | I_RW,           O_PCE | O_BSY,        2, "brn exec");
    add(I_LD | I_RW,           O_IR | O_BSY,         3, "ld fetch");
    add(I_LD | I_RW,           O_BSY,                3, "ld decode");
    add(I_LD | I_RW | I_RDY,   O_BSY,                3, "ld exec");
    add(I_LD | I_RW,           O_MRQ | O_BSY,        3, "ld mem0");
    add(I_LD | I_RW,           O_MRQ | O_BSY,        3, "ld mem1");
    add(I_LD | I_RW,           O_MRQ | O_BSY,        3, "ld mem2");
    add(I_LD | I_RW | I_RDY,   O_MRQ | O_BSY,        3, "ld mem3");
    add(I_LD | I_RW,           O_PCE | O_RFW | O_WBS | O_BSY, 3, "ld wb");
    add(I_MW | I_LD,           O_IR | O_BSY,         4, "st fetch");
    add(I_MW | I_LD,           O_BSY,                4, "st decode");
    add(I_MW | I_LD,           O_BSY,                4, "st exec");
    add(I_MW | I_LD | I_RDY,   O_MRQ | O_MWE | O_PCE | O_BSY, 4, "st mem");
    add(I_MW | I_ACK,          O_IR | O_BSY,         5, "ack fetch");
    add(I_MW | I_ACK | I_BR,   O_BSY,                5, "ack decode");
    add(I_MW | I_RDY,          O_DONE,               5, "halt0");
    add(8'h00,                 O_DONE,               5, "halt1");
    add(I_ST,                  O_DONE,               5, "halt start");
    add(8'h00,                 O_IR | O_BSY,         0, "restart fetch");
    add(I_ACK,                 O_BSY,                0, "ack2 decode");
    add(8'h00,                 O_DONE,               0, "halt again");

    // ---------------- reset ----------------
    drive(8'h00);
    {bus4.Start, bus4.BranchEn, bus4.RegWrEn, bus4.MemWrEn,
     bus4.LoadInst, bus4.Ack, bus4.Taken, bus4.MemReady} = 8'h00;
    #22;
    chk("reset outs", 32'(outs()), 32'h0);
    chk("reset count", 32'(bus.InstCount), 32'h0);
    @(posedge Clk);
    #3 Reset = 1'b1;
    @(posedge Clk);
    #1;

    foreach (tbl[i]) begin
      cyc(tbl[i].in, tbl[i].exp, int'(tbl[i].cnt), tbl[i].name);
    end

    // ---------------- random stream against the model ----------------
    m_cnt = 0;
    cyc(I_ST, O_DONE, 0, "rnd restart");
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 14)));
    end

    // MemReady in the final allowed MEM cycle beats the timeout
    run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 14);
    run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 14);

    // ---------------- asynchronous reset mid-MEM ----------------
    cyc(I_LD, O_IR | O_BSY, m_cnt, "pre-rst fetch");
    cyc(I_LD, O_BSY, m_cnt, "pre-rst decode");
    cyc(I_LD, O_BSY, m_cnt, "pre-rst exec");
    drive(I_LD);
    #2;
    chk("mid-mem req", 32'(outs()), 32'(O_MRQ | O_BSY));
    #1 Reset = 1'b0;
    #1;
    chk("async rst outs", 32'(outs()), 32'h0);
    chk("async rst count", 32'(bus.InstCount), 32'h0);
    @(posedge Clk);
    #3;
    drive(I_ST);
    Reset = 1'b1;
    #1;
    chk("release idle", 32'(outs()), 32'h0);
    @(posedge Clk);
    #1;
    m_cnt = 0;

    // ---------------- store timeout into ERR ----------------
    cyc(I_MW, O_IR | O_BSY, 0, "to fetch");
    cyc(I_MW, O_BSY, 0, "to decode");
    cyc(I_MW, O_BSY, 0, "to exec");
    for (int k = 0; k < 15; k++) begin
      cyc(I_MW, O_MRQ | O_MWE | O_BSY, 0, "to mem");
    end
    for (int k = 0; k < 3; k++) begin
      cyc(I_MW | I_ST | I_RDY, O_ERR, 0, "err hold");
    end

    // ---------------- 4-bit counter saturation ----------------
    @(posedge Clk);
    #3 Reset4 = 1'b1;
    @(posedge Clk);
    #1;
    bus4.Start = 1'b1;
    bus4.RegWrEn = 1'b1;
    @(posedge Clk);
    #1;
    bus4.Start = 1'b0;
    repeat (56) @(posedge Clk);
    #1;
    chk("sat4 fetch outs", 32'(outs4()), 32'(O_IR | O_BSY));
    chk("sat4 count14", 32'(bus4.InstCount), 32'd14);
    repeat (4) @(posedge Clk);
    #1;
    chk("sat4 count15", 32'(bus4.InstCount), 32'd15);
    repeat (20) @(posedge Clk);
    #1;
    chk("sat4 count20", 32'(bus4.InstCount), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles in MEM waiting for MemReady before error (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16, width of retired-instruction counter.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  level-sampled request to begin execution.
REQ-006 BranchEn, RegWrEn, MemWrEn, LoadInst, Ack  input  1 each  decoded control flags for current instruction, valid from DECODE onward.
REQ-007 Taken  input  1  ALU branch condition, valid in EXEC.
REQ-008 MemReady  input  1  data-memory completion strobe.
REQ-009 IRWrEn  output  1  latch instruction register.
REQ-010 PCEn  output  1  advance program counter.
REQ-011 PCLoad  output  1  PC takes branch target instead of PC+1; only meaningful with PCEn.
REQ-012 RegFileWe  output  1  register-file write enable.
REQ-013 WbSel  output  1  writeback source: 1 = memory, 0 = ALU.
REQ-014 MemReq, MemWe  output  1 each  data-memory request / write qualifier.
REQ-015 Busy, Done, Err  output  1 each  status.
REQ-016 InstCount  output  CNT_W  retired-instruction count.

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-018 IDLE: all strobes 0; Start=1 -> FETCH next cycle; Start ignored in all states except IDLE and HALT.
REQ-019 FETCH: IRWrEn=1 for exactly one cycle -> DECODE.
REQ-020 DECODE: Ack=1 -> HALT (takes priority over every other flag); else -> EXEC.
REQ-021 EXEC, BranchEn=1: PCEn=1, PCLoad=Taken -> FETCH; retires.
REQ-022 EXEC, BranchEn=0 and (MemWrEn or LoadInst): -> MEM; MemWrEn and LoadInst both 1 treated as store.
REQ-023 EXEC, otherwise: -> WB.
REQ-024 MEM: MemReq=1, MemWe=MemWrEn every cycle until MemReady=1; MemReady sampled only in MEM, ignored elsewhere.
REQ-025 MEM with MemReady=1: store -> PCEn=1 same cycle, retires, -> FETCH; load -> WB.
REQ-026 MEM wait counter SHALL clear on MEM entry; if MemReady still 0 after MEM_TIMEOUT consecutive MEM cycles, -> ERR; MemReady in the final allowed cycle wins over timeout.
REQ-027 WB: RegFileWe=RegWrEn, WbSel=LoadInst, PCEn=1, PCLoad=0; retires; -> FETCH.
REQ-028 HALT: Done=1 held; Start=1 -> FETCH, Done drops same edge, InstCount clears to 0.
REQ-029 ERR: Err=1, all strobes 0, terminal until Reset.
REQ-030 Busy=1 in FETCH, DECODE, EXEC, MEM, WB; 0 otherwise.
REQ-031 InstCount SHALL increment by 1 on each retiring cycle (every PCEn=1 cycle), saturate at all-ones; the Ack instruction does not count.
REQ-032 Strobes SHALL be decoded from current state (and Taken/MemReady/flags where stated), at most one PCEn pulse per instruction.
REQ-033 Latency: ALU instruction 4 cycles FETCH-to-retire, branch 3, store 3+wait, load 4+wait.

Reset
REQ-034 Reset low SHALL asynchronously force IDLE, all outputs 0, InstCount 0, wait counter 0, including mid-MEM (MemReq drops immediately).
REQ-035 First state change after Reset deasserts SHALL occur no earlier than the next rising Clk.

Verification
REQ-036 Reset, Start=1 one cycle, ALU flags (RegWrEn=1) -> IRWrEn cycle 1, RegFileWe+PCEn cycle 4, InstCount=1.
REQ-037 Branch BranchEn=1, Taken=1 -> PCEn=1, PCLoad=1 in EXEC; Taken=0 -> PCLoad=0; neither writes registers.
REQ-038 Load, MemReady after 3 wait cycles -> MemReq high 4 cycles, MemWe=0, then RegFileWe=1, WbSel=1.
REQ-039 Store, MemReady never asserted, MEM_TIMEOUT=15 -> ERR after 15 MEM cycles, Err=1, no PCEn, held until Reset.
REQ-040 Ack=1 with MemWrEn=1 in DECODE -> HALT, Done=1, no MemReq; then Start=1 -> FETCH, InstCount=0.
REQ-041 Reset asserted mid-MEM between edges -> MemReq, Busy 0 immediately; CNT_W=4 run of 20 ALU instructions -> InstCount=15.
